uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Byte-wide UART transmitter that replaces the stubbed serial path in the SoC: accepts bytes from the bus-side write port into a small FIFO and serialises them onto `uart_tx` as 8N1 frames at a fixed clock divider. Sits directly upstream of the `uart_tx` pad. It also produces the UART transmit-complete interrupt source.

## Interface
- `CLK_DIV`, 16, clock cycles per serial bit; legal range ≥ 2.
- `FIFO_DEPTH`, 8, byte entries in the transmit FIFO; power of two, ≥ 2.

Ports:
- `clk` input 1: system clock; the single clock for the whole block.
- `rst_n` input 1: asynchronous, active-low reset.
- `wr_data` input 8: byte to transmit.
- `wr_valid` input 1: write request.
- `wr_ready` output 1: FIFO can accept; equals not-full.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high when the FSM is not IDLE or the FIFO is non-empty.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `tx_done_int` output 1: one-cycle pulse when transmission completes with the FIFO empty.

## Operation
- A write is accepted on a rising edge where `wr_valid && wr_ready`. A write is never accepted while the FIFO is full, even if a pop happens in the same cycle.
- Push and pop on the same edge leave `fifo_level` unchanged. Otherwise `fifo_level` changes by +1 or −1.
- FSM states and transitions:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for `CLK_DIV` cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held for `CLK_DIV` cycles, then go to STOP.
  - STOP: `tx`=1 for `CLK_DIV` cycles.
    - If the FIFO is non-empty at the last STOP cycle, pop and go straight to START, with no idle gap.
    - Otherwise go to IDLE and pulse `tx_done_int`.
- Bit timing: a baud counter runs 0..`CLK_DIV`−1 and is cleared on every state/bit change. The bit index runs 0..7.
- `tx` is a registered output (no glitches).
- Reset values: `tx`=1, `wr_ready`=1, `busy`=0, `fifo_level`=0, `tx_done_int`=0.
- Reset asserted mid-frame: `tx` returns to 1 asynchronously, the FIFO is emptied, and the FSM goes to IDLE. The aborted byte is lost and no `tx_done_int` pulse is issued.

## Timing
- Acceptance edge E0 → FIFO non-empty after E0 → at E1 the FSM pops and `tx` goes low. Latency from write to start bit is 1 cycle.
- A full frame occupies exactly 10×`CLK_DIV` cycles. Back-to-back frames are contiguous.
- `tx_done_int` is high for exactly one cycle: the first IDLE cycle after the final STOP cycle.
- `wr_ready` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the next pop.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - `UART_DATA_BITS`=8;
  - the stop-bit and idle-level constants.
- One sub-module, `uart_sync_fifo`: parameterised width and depth, with pointer wrap via an extra MSB, full/empty flags, and a level output. The FSM, baud counter and shift register live in `uart_tx_engine`.

## Test plan
All scenarios use `CLK_DIV`=4 and `FIFO_DEPTH`=4.
- Reset release, no writes → `tx`=1, `wr_ready`=1, `busy`=0, `fifo_level`=0, and `tx_done_int` never pulses for 100 cycles.
- Write 0xA5 at E0:
  - `tx` is 0 for cycles E1..E4, then 1,0,1,0,0,1,0,1 with 4 cycles each, then stop high for 4 cycles;
  - `tx_done_int` pulses once at cycle E1+40;
  - `busy` then drops.
- Six consecutive writes 0x01..0x06:
  - 0x01..0x05 are accepted on E0..E4;
  - `wr_ready`=0 from E5 until the first frame's last STOP pop;
  - the 0x06 write is then accepted;
  - six contiguous frames with no idle cycles, and a single `tx_done_int` at the end.
- With `fifo_level`=2 and the FSM in STOP, write on the same edge as the end-of-frame pop → `fifo_level` stays 2.
- Assert `rst_n` low during DATA bit 3 of 0x3C with two bytes queued:
  - `tx`=1 immediately and `fifo_level`=0;
  - after release, nothing is transmitted and `tx_done_int` stays 0.
- Fill the FIFO (level 4), then hold `wr_valid` during the pop edge → no write is accepted that edge and the level goes to 3.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Items shared by the UART transmit path:
//   - UART_DATA_BITS   : payload bits per frame (8N1 framing)
//   - line levels      : idle, start and stop levels of the serial line
//   - uart_state_e     : transmitter FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Serial line levels. The line idles at the mark level, and the stop
    // bit uses the same level, so back-to-back frames need no idle gap.
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_STOP_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_engine_if.sv
// ---------------------------------------------------------------------------
// uart_tx_engine_if
// Byte write port of the UART transmitter. A byte is transferred on a
// rising clock edge where wr_valid and wr_ready are both high.
//   wr_data  : byte to transmit            (master -> slave)
//   wr_valid : write request               (master -> slave)
//   wr_ready : transmit FIFO not full      (slave  -> master)
// ---------------------------------------------------------------------------
interface uart_tx_engine_if
    import uart_pkg::*;
();

    logic [UART_DATA_BITS-1:0] wr_data;
    logic                      wr_valid;
    logic                      wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with first-word fall-through read data. Pointers carry
// one extra MSB so that full and empty can be told apart when the index
// bits are equal.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push_i     : write wdata_i; ignored while full
//   wdata_i    : write data
//   pop_i      : discard the head entry; ignored while empty
//   rdata_o    : head entry (valid while !empty_o)
//   full_o     : DEPTH entries stored
//   empty_o    : no entries stored
//   level_o    : current occupancy, 0..DEPTH
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      wptr_d;
    logic [AW:0]      rptr_q;
    logic [AW:0]      rptr_d;
    logic             push_en;
    logic             pop_en;

    // Full: same index, opposite wrap bit. A pop on the same edge does not
    // make room for a push, because full_o is evaluated before the edge.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);

    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    assign wptr_d  = push_en ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d  = pop_en  ? rptr_q + 1'b1 : rptr_q;

    // Modulo-2^(AW+1) difference gives the occupancy directly.
    assign level_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only
    // ever read after being written, and resetting it would force flops
    // where a plain RAM would do.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
// Byte-wide UART transmitter: bytes written through the write port are
// queued in a FIFO and serialised onto tx as 8N1 frames, LSB first, each
// bit held for CLK_DIV clock cycles. Frames queued back to back go out with
// no idle gap between the stop bit and the next start bit.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_if       : byte write port (wr_data / wr_valid / wr_ready)
//   tx          : registered serial output, idle high
//   busy        : frame in progress or FIFO non-empty
//   fifo_level  : transmit FIFO occupancy
//   tx_done_int : one-cycle pulse on the first idle cycle after the last
//                 queued frame's stop bit
// CLK_DIV >= 2; FIFO_DEPTH is a power of two, >= 2.
// ---------------------------------------------------------------------------
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_tx_engine_if.slave             wr_if,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        tx_done_int
);

    localparam int                BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam int                BIT_W     = $clog2(UART_DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    localparam logic [1:0] ST_IDLE  = UART_IDLE;
    localparam logic [1:0] ST_START = UART_START;
    localparam logic [1:0] ST_DATA  = UART_DATA;
    localparam logic [1:0] ST_STOP  = UART_STOP;

    logic [1:0]                state_q;
    logic [1:0]                state_d;
    logic [BAUD_W-1:0]         baud_q;
    logic [BAUD_W-1:0]         baud_d;
    logic [BIT_W-1:0]          bit_q;
    logic [BIT_W-1:0]          bit_d;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] shift_d;
    logic                      tx_q;
    logic                      tx_d;
    logic                      done_q;
    logic                      done_d;

    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_rdata;

    // -----------------------------------------------------------------------
    // Transmit FIFO. The FIFO itself refuses pushes while full, so wr_valid
    // can be passed straight through.
    // -----------------------------------------------------------------------
    uart_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wr_if.wr_valid),
        .wdata_i (wr_if.wr_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign wr_if.wr_ready = !fifo_full;

    // -----------------------------------------------------------------------
    // Next-state logic. tx_d is the line level for the cycle after the edge,
    // so it is derived from where the FSM is going, not where it is.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = UART_IDLE_LEVEL;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    baud_d   = '0;
                    state_d  = ST_START;
                    tx_d     = UART_START_LEVEL;
                end
            end

            ST_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                        tx_d    = UART_STOP_LEVEL;
                    end else begin
                        // Bit 0 of the shift register is always on the line;
                        // bit 1 becomes the next line level after the shift.
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = ST_START;
                        tx_d     = UART_START_LEVEL;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = UART_IDLE_LEVEL;
                        done_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = UART_IDLE_LEVEL;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers. Reset forces the line high immediately, abandoning
    // any frame in flight without a completion pulse.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx          = tx_q;
    assign tx_done_int = done_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
// Self-checking bench for uart_tx_engine with CLK_DIV=4, FIFO_DEPTH=4.
// A frame-level reference model (byte queue plus a position within the
// current 10-bit frame) predicts every output each cycle; directed scenarios
// add hand-computed expectations at the points of interest.
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int FRAME   = 10 * CLK_DIV;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             tx;
    logic             busy;
    logic             tx_done_int;
    logic [LVL_W-1:0] fifo_level;

    uart_tx_engine_if wr_if ();

    uart_tx_engine #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_if       (wr_if),
        .tx          (tx),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .tx_done_int (tx_done_int)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int done_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: bytes waiting, and the current frame as a position
    // 0..FRAME-1. The line level is the frame bit at position/CLK_DIV.
    // -----------------------------------------------------------------------
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_cur    = 8'h00;
    bit         m_done   = 1'b0;
    bit         m_accept;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_done   = 1'b0;
        end else begin
            m_accept = wr_if.wr_valid && (m_q.size() < DEPTH);
            m_done   = 1'b0;
            if (!m_active) begin
                if (m_q.size() > 0) begin
                    m_cur    = m_q.pop_front();
                    m_active = 1'b1;
                    m_pos    = 0;
                end
            end else if (m_pos == FRAME - 1) begin
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                    m_pos = 0;
                end else begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else begin
                m_pos++;
            end
            if (m_accept) m_q.push_back(wr_if.wr_data);
        end
    end

    function automatic logic exp_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_pos / CLK_DIV;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (tx_done_int === 1'b1) done_count++;
        check("tx",          tx,             exp_tx());
        check("wr_ready",    wr_if.wr_ready, m_q.size() < DEPTH);
        check("busy",        busy,           m_active || (m_q.size() > 0));
        check("fifo_level",  fifo_level,     m_q.size());
        check("tx_done_int", tx_done_int,    m_done);
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers. Called just after a falling edge; return just after
    // the falling edge that follows the accepting rising edge, with wr_valid
    // still high so back-to-back writes stay contiguous.
    // -----------------------------------------------------------------------
    task automatic write_byte(input logic [7:0] d, output int edge_n);
        edge_n          = -1;
        wr_if.wr_valid  = 1'b1;
        wr_if.wr_data   = d;
        for (int i = 0; i < 200; i++) begin
            if (wr_if.wr_ready === 1'b1) begin
                edge_n = cyc + 1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        check("write_accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input int limit, output int edge_n);
        edge_n = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tx_done_int === 1'b1) begin
                edge_n = cyc;
                return;
            end
        end
        check("done_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Directed scenarios
    // -----------------------------------------------------------------------
    int         e0;
    int         de;
    int         d0;
    int         acc[6];
    int         b0, b1, b2, b3;
    int         c0, c1, c2;
    logic [9:0] a5_frame;

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 8'h00;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Reset values and a quiet line.
        check("rst_tx",       tx,             1);
        check("rst_wr_ready", wr_if.wr_ready, 1);
        check("rst_busy",     busy,           0);
        check("rst_level",    fifo_level,     0);
        d0 = done_count;
        repeat (100) @(negedge clk);
        check("idle_done_pulses", done_count - d0, 0);
        check("idle_tx",          tx,              1);

        // Single byte 0xA5: start, LSB-first data, stop.
        a5_frame = {1'b1, 8'hA5, 1'b0};
        write_byte(8'hA5, e0);
        wr_if.wr_valid = 1'b0;
        check("a5_level_after_write", fifo_level, 1);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            check("a5_tx", tx, a5_frame[(k-1)/CLK_DIV]);
        end
        @(negedge clk);
        check("a5_done", tx_done_int, 1);
        check("a5_busy", busy,        0);
        @(negedge clk);
        check("a5_done_single", tx_done_int, 0);

        // Six writes into a four-deep FIFO.
        repeat (3) @(negedge clk);
        d0 = done_count;
        for (int i = 0; i < 5; i++) write_byte(8'(i + 1), acc[i]);
        for (int i = 1; i < 5; i++) check("six_accept_edge", acc[i] - acc[0], i);
        wr_if.wr_data = 8'h06;
        check("six_full_ready", wr_if.wr_ready, 0);
        check("six_full_level", fifo_level,     4);
        while (cyc < acc[0] + 41) @(negedge clk);
        check("six_level_after_pop", fifo_level,     3);
        check("six_ready_after_pop", wr_if.wr_ready, 1);
        write_byte(8'h06, acc[5]);
        wr_if.wr_valid = 1'b0;
        check("six_sixth_accept_edge", acc[5] - acc[0], 42);
        wait_done(400, de);
        check("six_done_edge", de - acc[0], 1 + 6 * FRAME);
        @(negedge clk);
        check("six_done_count", done_count - d0, 1);
        check("six_busy_end",   busy,            0);

        // Write on the same edge as the end-of-frame pop at level 2.
        repeat (3) @(negedge clk);
        write_byte(8'h81, b0);
        write_byte(8'h42, b1);
        write_byte(8'h24, b2);
        wr_if.wr_valid = 1'b0;
        check("same_level_setup", fifo_level, 2);
        while (cyc < b0 + 40) @(negedge clk);
        check("same_level_before", fifo_level, 2);
        write_byte(8'h99, b3);
        wr_if.wr_valid = 1'b0;
        check("same_accept_edge", b3 - b0, 41);
        check("same_level_after", fifo_level, 2);
        wait_done(300, de);
        check("same_done_edge", de - b0, 1 + 4 * FRAME);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        repeat (3) @(negedge clk);
        write_byte(8'h3C, c0);
        write_byte(8'h11, c1);
        write_byte(8'h22, c2);
        wr_if.wr_valid = 1'b0;
        while (cyc < c0 + 18) @(negedge clk);
        check("rst_mid_level_before", fifo_level, 2);
        check("rst_mid_tx_bit3",      tx,         1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx",       tx,             1);
        check("rst_mid_level",    fifo_level,     0);
        check("rst_mid_busy",     busy,           0);
        check("rst_mid_wr_ready", wr_if.wr_ready, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        d0 = done_count;
        repeat (100) @(negedge clk);
        check("rst_mid_no_done", done_count - d0, 0);
        check("rst_mid_tx_idle", tx,              1);
        check("rst_mid_level_end", fifo_level,    0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
